secret_accum_sched: RTL and testbench

//  Schedules a single shared `secret` accumulator instance among NREQ requesters.
//  - Grants one requester at a time (round-robin) and drives accum_in/accum_bypass.
//  - Snapshots accum_out, because the secret block has no reset.
//  - Returns each requester's accumulation delta or its bypass value as a tagged response.

---
 rtl/secret_accum_sched.sv | 172 +++++++++++++++++
 tb/tb_secret_accum_sched.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/secret_accum_sched.sv
// Round-robin scheduler for one shared reset-less accumulator: snapshots its base, runs one job, returns delta or bypass value.
// Latency grant->rsp: count+1 edges (accumulate), 1 edge (bypass); no rsp backpressure, requests wait in req_valid until granted.
module secret_accum_sched #(
    parameter int NREQ         = 4,
    parameter int CNT_W        = 8,
    parameter int SECRET_VALUE = 7,
    localparam int ID_W        = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ-1:0]       req_mode,
    input  logic [NREQ*32-1:0]    req_operand,
    input  logic [NREQ*CNT_W-1:0] req_count,
    output logic                  rsp_valid,
    output logic [ID_W-1:0]       rsp_id,
    output logic [31:0]           rsp_data,
    output logic                  busy,
    output logic [31:0]           accum_in,
    output logic                  accum_bypass,
    input  logic [31:0]           accum_out,
    input  logic [31:0]           accum_bypass_out
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_BYP   = 2'd3
    } state_t;

    localparam logic [31:0] SECRET_W = 32'(SECRET_VALUE);
    localparam logic [ID_W:0] NREQ_W = (ID_W+1)'(NREQ);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NREQ - 1);

    state_t            state_q, state_d;
    logic [ID_W-1:0]   rr_q, rr_d;
    logic [31:0]       op_q, op_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [31:0]       base_q, base_d;
    logic [NREQ-1:0]   req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [31:0]       rsp_data_q, rsp_data_d;

    logic [2*NREQ-1:0] arb_dbl;
    logic [NREQ-1:0]   arb_rot;
    logic              arb_found;
    logic [ID_W-1:0]   arb_off;
    logic [ID_W:0]     arb_sum;
    logic [ID_W-1:0]   arb_win;
    logic [31:0]       win_op;
    logic [CNT_W-1:0]  win_cnt;

    // Rotate the request vector so the rr pointer sits at bit 0; the lowest set bit is the winner.
    always_comb begin
        arb_dbl   = {req_valid, req_valid};
        arb_rot   = NREQ'(arb_dbl >> rr_q);
        arb_found = |arb_rot;
        arb_off   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (arb_rot[k]) begin
                arb_off = ID_W'(k);
            end
        end
        arb_sum = {1'b0, rr_q} + {1'b0, arb_off};
        if (arb_sum >= NREQ_W) begin
            arb_sum = arb_sum - NREQ_W;
        end
        arb_win = arb_sum[ID_W-1:0];
        win_op  = req_operand[32*arb_win +: 32];
        win_cnt = req_count[CNT_W*arb_win +: CNT_W];
    end

    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        op_d         = op_q;
        cnt_d        = cnt_q;
        id_d         = id_q;
        base_d       = base_q;
        req_ready_d  = '0;
        rsp_valid_d  = 1'b0;
        rsp_id_d     = rsp_id_q;
        rsp_data_d   = rsp_data_q;
        accum_in     = '0;
        accum_bypass = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (arb_found) begin
                    req_ready_d = NREQ'(1) << arb_win;
                    op_d        = win_op;
                    cnt_d       = win_cnt;
                    id_d        = arb_win;
                    base_d      = accum_out;
                    rr_d        = (arb_win == LAST_ID) ? '0 : arb_win + 1'b1;
                    if (req_mode[arb_win]) begin
                        state_d = S_BYP;
                    end else if (win_cnt == '0) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                accum_in = op_q;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_DRAIN;
                end
                cnt_d = cnt_q - 1'b1;
            end
            S_DRAIN: begin
                // The grant edge itself added SECRET_VALUE on top of the snapshot, so remove it.
                rsp_valid_d = 1'b1;
                rsp_data_d  = accum_out - base_q - SECRET_W;
                rsp_id_d    = id_q;
                state_d     = S_IDLE;
            end
            S_BYP: begin
                accum_in     = op_q;
                accum_bypass = 1'b1;
                rsp_valid_d  = 1'b1;
                rsp_data_d   = accum_bypass_out;
                rsp_id_d     = id_q;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rr_q        <= '0;
            op_q        <= '0;
            cnt_q       <= '0;
            id_q        <= '0;
            base_q      <= '0;
            req_ready_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            id_q        <= id_d;
            base_q      <= base_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = (state_q != S_IDLE);

    a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ready));
    a_rsp_pulse:    assert property (@(posedge clk) disable iff (!rst_n) rsp_valid |=> !rsp_valid);

endmodule

// File: tb/tb_secret_accum_sched.sv
// Bench for secret_accum_sched: behavioural model of the secret block, directed vector table, corner sequences, random traffic.
module tb_secret_accum_sched;
    localparam int NREQ  = 4;
    localparam int CNT_W = 8;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       req_mode;
    logic [NREQ*32-1:0]    req_operand;
    logic [NREQ*CNT_W-1:0] req_count;
    logic                  rsp_valid;
    logic [1:0]            rsp_id;
    logic [31:0]           rsp_data;
    logic                  busy;
    logic [31:0]           accum_in;
    logic                  accum_bypass;
    logic [31:0]           accum_out;
    logic [31:0]           accum_bypass_out;

    secret_accum_sched #(.NREQ(NREQ), .CNT_W(CNT_W), .SECRET_VALUE(7)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
        .req_operand(req_operand), .req_count(req_count),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy),
        .accum_in(accum_in), .accum_bypass(accum_bypass),
        .accum_out(accum_out), .accum_bypass_out(accum_bypass_out)
    );

    always #5 clk = ~clk;

    // Reset-less secret block: adds accum_in + 7 every edge.
    logic [31:0] sec_acc;
    logic        preload;
    logic [31:0] preload_val;
    always @(posedge clk) sec_acc <= preload ? preload_val : sec_acc + accum_in + 32'd7;
    assign accum_out        = sec_acc;
    assign accum_bypass_out = accum_bypass ? accum_in : sec_acc;

    int cyc = 0;
    int mon_nz = 0;
    int mon_byp = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        mon_nz  <= mon_nz + int'(accum_in != 32'd0);
        mon_byp <= mon_byp + int'(accum_bypass);
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input int id, input bit mode, input logic [31:0] op, input logic [7:0] cnt);
        req_mode[id]               = mode;
        req_operand[32*id +: 32]   = op;
        req_count[CNT_W*id +: CNT_W] = cnt;
    endtask

    task automatic wait_ready(input int budget, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < budget && !ok; t++) begin
            @(negedge clk);
            if (req_ready != '0) ok = 1'b1;
        end
    endtask

    task automatic wait_rsp(input int budget, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < budget && !ok; t++) begin
            @(negedge clk);
            if (rsp_valid) ok = 1'b1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One isolated request: grant, scrambled inputs after grant, response value, latency, accumulator drive.
    task automatic do_req(input string nm, input int id, input bit mode, input logic [31:0] op,
                          input logic [7:0] cnt, input logic [31:0] exp, input int lat,
                          input int exp_nz, input int exp_byp);
        bit ok;
        int g, nz0, byp0;
        logic [31:0] held;
        @(negedge clk);
        nz0  = mon_nz;
        byp0 = mon_byp;
        drive(id, mode, op, cnt);
        req_valid = NREQ'(1) << id;
        wait_ready(50, ok);
        chk({nm, " grant seen"}, 32'(ok), 32'd1);
        if (!ok) return;
        chk({nm, " ready"}, 32'(req_ready), 32'(1) << id);
        g = cyc;
        req_valid   = '0;
        req_mode    = NREQ'($urandom());
        req_operand = {$urandom(), $urandom(), $urandom(), $urandom()};
        req_count   = 32'($urandom());
        wait_rsp(400, ok);
        chk({nm, " rsp seen"}, 32'(ok), 32'd1);
        if (!ok) return;
        chk({nm, " rsp_id"}, 32'(rsp_id), 32'(id));
        chk({nm, " rsp_data"}, rsp_data, exp);
        chk({nm, " latency"}, 32'(cyc - g), 32'(lat));
        chk({nm, " accum_in active cycles"}, 32'(mon_nz - nz0), 32'(exp_nz));
        chk({nm, " bypass cycles"}, 32'(mon_byp - byp0), 32'(exp_byp));
        held = rsp_data;
        @(negedge clk);
        chk({nm, " rsp pulse"}, 32'(rsp_valid), 32'd0);
        chk({nm, " rsp hold"}, rsp_data, held);
    endtask

    typedef struct {
        string       nm;
        int          id;
        bit          mode;
        logic [31:0] op;
        logic [7:0]  cnt;
        logic [31:0] exp;
        int          lat;
        int          nz;
        int          byp;
    } vec_t;
    vec_t vecs[6];

    // Random-phase model state.
    bit              pend[NREQ];
    bit              pm[NREQ];
    logic [31:0]     po[NREQ];
    logic [7:0]      pc[NREQ];
    logic [NREQ-1:0] vprev, exp_gnt;
    bit              outst, found;
    int              mrr, ew, o_id, o_g, o_lat;
    logic [31:0]     o_exp;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        vecs[0] = '{"v_acc5x4",  0, 1'b0, 32'd5,          8'd4,   32'd48,         5,   4,   0};
        vecs[1] = '{"v_cnt0",    2, 1'b0, 32'd99,         8'd0,   32'd0,          1,   0,   0};
        vecs[2] = '{"v_byp",     1, 1'b1, 32'hDEADBEEF,   8'd9,   32'hDEADBEEF,   1,   1,   1};
        vecs[3] = '{"v_wrap",    3, 1'b0, 32'hFFFFFFFF,   8'd2,   32'd12,         3,   2,   0};
        vecs[4] = '{"v_cnt255",  1, 1'b0, 32'h10,         8'd255, 32'd5865,       256, 255, 0};
        vecs[5] = '{"v_byp0",    2, 1'b1, 32'd0,          8'd0,   32'd0,          1,   0,   1};

        rst_n = 1'b1; preload = 1'b1; preload_val = 32'h1234_5678;
        req_valid = '0; req_mode = '0; req_operand = '0; req_count = '0;
        #1 rst_n = 1'b0;
        #1;
        chk("reset req_ready", 32'(req_ready), 32'd0);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_id", 32'(rsp_id), 32'd0);
        chk("reset rsp_data", rsp_data, 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset accum_in", accum_in, 32'd0);
        chk("reset accum_bypass", 32'(accum_bypass), 32'd0);
        repeat (3) @(negedge clk);
        preload = 1'b0;
        rst_n = 1'b1;

        for (int v = 0; v < 6; v++)
            do_req(vecs[v].nm, vecs[v].id, vecs[v].mode, vecs[v].op, vecs[v].cnt,
                   vecs[v].exp, vecs[v].lat, vecs[v].nz, vecs[v].byp);

        // Base just below 2^32 so the accumulation wraps.
        @(negedge clk);
        preload_val = 32'hFFFF_FFFF - 32'd7000 - 32'd9;
        preload = 1'b1;
        @(negedge clk);
        preload = 1'b0;
        repeat (1000) @(negedge clk);
        do_req("wrap_hi_base", 3, 1'b0, 32'hFFFFFFFF, 8'd2, 32'd12, 3, 2, 0);

        // All four held valid: strict rotation starting at 0 after reset.
        do_reset();
        for (int i = 0; i < NREQ; i++) drive(i, 1'b0, 32'd0, 8'd1);
        req_valid = '1;
        for (int k = 0; k < 5; k++) begin
            wait_ready(20, ok);
            chk("rr grant seen", 32'(ok), 32'd1);
            chk("rr order", 32'(req_ready), 32'(1) << (k % NREQ));
            wait_rsp(20, ok);
            chk("rr rsp seen", 32'(ok), 32'd1);
            chk("rr rsp_data", rsp_data, 32'd7);
            chk("rr rsp_id", 32'(rsp_id), 32'(k % NREQ));
        end
        req_valid = '0;

        // Reset in the middle of a long accumulation.
        do_reset();
        @(negedge clk);
        drive(0, 1'b0, 32'd3, 8'd40);
        req_valid = 4'b0001;
        wait_ready(20, ok);
        chk("midrun grant seen", 32'(ok), 32'd1);
        req_valid = '0;
        repeat (5) @(negedge clk);
        chk("midrun busy before reset", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrun reset accum_in", accum_in, 32'd0);
        chk("midrun reset busy", 32'(busy), 32'd0);
        chk("midrun reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrun reset req_ready", 32'(req_ready), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_rsp(60, ok);
        chk("midrun no rsp after reset", 32'(ok), 32'd0);
        do_req("post_reset_req3", 3, 1'b0, 32'd1, 8'd1, 32'd8, 2, 1, 0);

        // Random traffic against the arbitration/result model.
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 1'b0; pm[i] = 1'b0; po[i] = '0; pc[i] = '0;
        end
        vprev = '0; outst = 1'b0; mrr = 0; o_id = 0; o_g = 0; o_lat = 0; o_exp = '0; ew = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            exp_gnt = '0;
            if (!outst && vprev != '0) begin
                found = 1'b0;
                for (int k = 0; k < NREQ; k++) begin
                    if (!found && vprev[(mrr + k) % NREQ]) begin
                        found = 1'b1;
                        ew = (mrr + k) % NREQ;
                    end
                end
                exp_gnt = NREQ'(1) << ew;
            end
            chk("rnd req_ready", 32'(req_ready), 32'(exp_gnt));
            if (exp_gnt != '0) begin
                outst = 1'b1;
                o_id  = ew;
                o_g   = cyc;
                o_exp = pm[ew] ? po[ew] : 32'(pc[ew]) * (po[ew] + 32'd7);
                o_lat = pm[ew] ? 1 : int'(pc[ew]) + 1;
                mrr   = (ew + 1) % NREQ;
                pend[ew] = 1'b0;
            end
            if (rsp_valid) begin
                chk("rnd rsp expected", 32'(outst), 32'd1);
                chk("rnd rsp_id", 32'(rsp_id), 32'(o_id));
                chk("rnd rsp_data", rsp_data, o_exp);
                chk("rnd latency", 32'(cyc - o_g), 32'(o_lat));
                outst = 1'b0;
            end else if (outst && (cyc - o_g) > o_lat) begin
                chk("rnd rsp missing", 32'(rsp_valid), 32'd1);
                outst = 1'b0;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (c >= 3500) begin
                    pend[i] = 1'b0;
                end else if (!pend[i] && $urandom_range(3) == 0) begin
                    pend[i] = 1'b1;
                    pm[i]   = ($urandom_range(4) == 0);
                    po[i]   = $urandom();
                    pc[i]   = ($urandom_range(6) == 0) ? 8'($urandom()) : 8'($urandom_range(5));
                end else if (pend[i] && $urandom_range(40) == 0) begin
                    pend[i] = 1'b0;
                end
                req_mode[i]                  = pm[i];
                req_operand[32*i +: 32]      = po[i];
                req_count[CNT_W*i +: CNT_W]  = pc[i];
                req_valid[i]                 = pend[i];
            end
            vprev = req_valid;
        end
        chk("rnd drained", 32'(outst), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
